// File: rtl/pipe_front_regs.sv
// Front-end pipeline state: PC, IF/ID and ID/EX registers with stall/flush
// handling and saturating trace counters for the stall and redirect events.
module pipe_front_regs #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned BUNDLE_W = 96,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                cpu_clk,
    input  logic                cpu_rst,
    input  logic                stop_IF_ID,
    input  logic                stop_ID_EX,
    input  logic                br_taken,
    input  logic [31:0]         br_target,
    input  logic [31:0]         if_inst,
    input  logic [4:0]          id_rs1,
    input  logic [4:0]          id_rs2,
    input  logic [4:0]          id_wr,
    input  logic                id_isLoad,
    input  logic                id_reg_we,
    input  logic [BUNDLE_W-1:0] id_bundle,
    output logic [31:0]         pc,
    output logic [31:0]         id_pc,
    output logic [31:0]         id_inst,
    output logic                id_valid,
    output logic [31:0]         ex_pc,
    output logic [4:0]          ex_wr,
    output logic                ex_isLoad,
    output logic                ex_reg_we,
    output logic [BUNDLE_W-1:0] ex_bundle,
    output logic                ex_valid,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    flush_cnt
);

    localparam logic [31:0]      NopInst = 32'h0000_0013;
    localparam logic [CNT_W-1:0] CntMax  = '1;

    typedef enum logic [1:0] {ActFlush, ActStall, ActBubble, ActAdvance} act_e;

    act_e act;

    logic [31:0]         pc_q, pc_d;
    logic [31:0]         id_pc_q, id_pc_d;
    logic [31:0]         id_inst_q, id_inst_d;
    logic                id_valid_q, id_valid_d;
    logic [31:0]         ex_pc_q, ex_pc_d;
    logic [4:0]          ex_wr_q, ex_wr_d;
    logic                ex_isLoad_q, ex_isLoad_d;
    logic                ex_reg_we_q, ex_reg_we_d;
    logic [BUNDLE_W-1:0] ex_bundle_q, ex_bundle_d;
    logic                ex_valid_q, ex_valid_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;

    // rs1/rs2 are consumed by the hazard unit directly; nothing here latches them.
    logic unused_rs;
    assign unused_rs = ^{id_rs1, id_rs2};

    // Priority decode of this cycle's pipeline action: redirect beats stall beats bubble.
    always_comb begin
        if (br_taken) begin
            act = ActFlush;
        end else if (stop_IF_ID) begin
            act = ActStall;
        end else if (stop_ID_EX) begin
            act = ActBubble;
        end else begin
            act = ActAdvance;
        end
    end

    // Next-state: ID/EX defaults to a bubble, IF/ID and PC default to hold.
    always_comb begin
        pc_d        = pc_q;
        id_pc_d     = id_pc_q;
        id_inst_d   = id_inst_q;
        id_valid_d  = id_valid_q;
        ex_pc_d     = '0;
        ex_wr_d     = '0;
        ex_isLoad_d = 1'b0;
        ex_reg_we_d = 1'b0;
        ex_bundle_d = '0;
        ex_valid_d  = 1'b0;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        unique case (act)
            ActFlush: begin
                pc_d       = br_target;
                id_pc_d    = '0;
                id_inst_d  = NopInst;
                id_valid_d = 1'b0;
                if (flush_cnt_q != CntMax) begin
                    flush_cnt_d = flush_cnt_q + CNT_W'(1);
                end
            end
            ActStall: begin
                if (stall_cnt_q != CntMax) begin
                    stall_cnt_d = stall_cnt_q + CNT_W'(1);
                end
            end
            ActBubble: begin
                pc_d       = pc_q + 32'd4;
                id_pc_d    = pc_q;
                id_inst_d  = if_inst;
                id_valid_d = 1'b1;
            end
            ActAdvance: begin
                pc_d       = pc_q + 32'd4;
                id_pc_d    = pc_q;
                id_inst_d  = if_inst;
                id_valid_d = 1'b1;
                // An empty IF/ID slot must reach EX as a clean bubble.
                if (id_valid_q) begin
                    ex_pc_d     = id_pc_q;
                    ex_wr_d     = id_wr;
                    ex_isLoad_d = id_isLoad;
                    ex_reg_we_d = id_reg_we;
                    ex_bundle_d = id_bundle;
                    ex_valid_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // State registers with synchronous reset that overrides every request.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            pc_q        <= RESET_PC;
            id_pc_q     <= '0;
            id_inst_q   <= NopInst;
            id_valid_q  <= 1'b0;
            ex_pc_q     <= '0;
            ex_wr_q     <= '0;
            ex_isLoad_q <= 1'b0;
            ex_reg_we_q <= 1'b0;
            ex_bundle_q <= '0;
            ex_valid_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            id_pc_q     <= id_pc_d;
            id_inst_q   <= id_inst_d;
            id_valid_q  <= id_valid_d;
            ex_pc_q     <= ex_pc_d;
            ex_wr_q     <= ex_wr_d;
            ex_isLoad_q <= ex_isLoad_d;
            ex_reg_we_q <= ex_reg_we_d;
            ex_bundle_q <= ex_bundle_d;
            ex_valid_q  <= ex_valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pc        = pc_q;
    assign id_pc     = id_pc_q;
    assign id_inst   = id_inst_q;
    assign id_valid  = id_valid_q;
    assign ex_pc     = ex_pc_q;
    assign ex_wr     = ex_wr_q;
    assign ex_isLoad = ex_isLoad_q;
    assign ex_reg_we = ex_reg_we_q;
    assign ex_bundle = ex_bundle_q;
    assign ex_valid  = ex_valid_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_front_regs.sv
// Bench for pipe_front_regs: directed scenarios plus randomized traffic against a
// behavioural model of the front-end pipeline. Counters are narrowed to 2 bits.
module tb_pipe_front_regs;

    localparam int unsigned BW = 96;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          cpu_clk = 1'b0;
    logic          cpu_rst = 1'b0;
    logic          stop_IF_ID = 1'b0;
    logic          stop_ID_EX = 1'b0;
    logic          br_taken = 1'b0;
    logic [31:0]   br_target = '0;
    logic [31:0]   if_inst;
    logic [4:0]    id_rs1 = '0;
    logic [4:0]    id_rs2 = '0;
    logic [4:0]    id_wr = '0;
    logic          id_isLoad = 1'b0;
    logic          id_reg_we = 1'b0;
    logic [BW-1:0] id_bundle = '0;
    logic [31:0]   pc, id_pc, id_inst, ex_pc;
    logic          id_valid, ex_isLoad, ex_reg_we, ex_valid;
    logic [4:0]    ex_wr;
    logic [BW-1:0] ex_bundle;
    logic [1:0]    stall_cnt, flush_cnt;

    int errors = 0;
    int checks = 0;

    // Behavioural model of the architectural pipeline contents
    logic [31:0]   m_pc, m_id_pc, m_id_inst, m_ex_pc;
    logic          m_id_valid, m_ex_isLoad, m_ex_reg_we, m_ex_valid;
    logic [4:0]    m_ex_wr;
    logic [BW-1:0] m_ex_bundle;
    int            m_stall, m_flush;

    pipe_front_regs #(
        .RESET_PC (32'h0000_0000),
        .BUNDLE_W (BW),
        .CNT_W    (2)
    ) dut (
        .cpu_clk    (cpu_clk),
        .cpu_rst    (cpu_rst),
        .stop_IF_ID (stop_IF_ID),
        .stop_ID_EX (stop_ID_EX),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .if_inst    (if_inst),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_wr      (id_wr),
        .id_isLoad  (id_isLoad),
        .id_reg_we  (id_reg_we),
        .id_bundle  (id_bundle),
        .pc         (pc),
        .id_pc      (id_pc),
        .id_inst    (id_inst),
        .id_valid   (id_valid),
        .ex_pc      (ex_pc),
        .ex_wr      (ex_wr),
        .ex_isLoad  (ex_isLoad),
        .ex_reg_we  (ex_reg_we),
        .ex_bundle  (ex_bundle),
        .ex_valid   (ex_valid),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    always #5 cpu_clk = ~cpu_clk;

    // Instruction ROM contents: a scrambled function of the address.
    function automatic logic [31:0] irom(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    assign if_inst = irom(pc);

    task automatic m_bubble();
        m_ex_pc = '0; m_ex_wr = '0; m_ex_isLoad = 0; m_ex_reg_we = 0;
        m_ex_bundle = '0; m_ex_valid = 0;
    endtask

    // Apply one clock edge of architectural behaviour using the inputs present now.
    task automatic model_edge();
        if (cpu_rst) begin
            m_pc = 32'h0; m_id_pc = 32'h0; m_id_inst = NOP; m_id_valid = 0;
            m_bubble();
            m_stall = 0; m_flush = 0;
        end else if (br_taken) begin
            m_pc = br_target; m_id_pc = 32'h0; m_id_inst = NOP; m_id_valid = 0;
            m_bubble();
            m_flush = (m_flush + 1 > 3) ? 3 : m_flush + 1;
        end else begin
            // A real instruction moves into EX only on a plain advance.
            if (!stop_IF_ID && !stop_ID_EX && m_id_valid) begin
                m_ex_pc = m_id_pc; m_ex_wr = id_wr; m_ex_isLoad = id_isLoad;
                m_ex_reg_we = id_reg_we; m_ex_bundle = id_bundle; m_ex_valid = 1;
            end else begin
                m_bubble();
            end
            if (stop_IF_ID) begin
                m_stall = (m_stall + 1 > 3) ? 3 : m_stall + 1;
            end else begin
                m_id_pc = m_pc; m_id_inst = irom(m_pc); m_id_valid = 1;
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        model_edge();
        #1;
    endtask

    task automatic clear_inputs();
        stop_IF_ID = 0; stop_ID_EX = 0; br_taken = 0; br_target = '0;
        id_rs1 = '0; id_rs2 = '0; id_wr = '0; id_isLoad = 0; id_reg_we = 0; id_bundle = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        cpu_rst = 1; tick(); tick(); cpu_rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want 0", pc); end
        checks++; if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_inst !== NOP) begin
            errors++; $display("FAIL rst_id got v=%b pc=%h inst=%h want v=0 pc=0 inst=%h",
                               id_valid, id_pc, id_inst, NOP);
        end
        checks++; if ({ex_valid, ex_wr, ex_isLoad, ex_reg_we, ex_pc, ex_bundle} !== '0) begin
            errors++; $display("FAIL rst_ex got v=%b wr=%0d pc=%h want all zero", ex_valid, ex_wr, ex_pc);
        end
        checks++; if (stall_cnt !== 2'd0 || flush_cnt !== 2'd0) begin
            errors++; $display("FAIL rst_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        end
        tick();
        checks++; if (pc !== 32'h4 || id_pc !== 32'h0 || id_inst !== irom(32'h0) || id_valid !== 1'b1) begin
            errors++; $display("FAIL adv1 got pc=%h id_pc=%h id_inst=%h want pc=4 id_pc=0 id_inst=%h",
                               pc, id_pc, id_inst, irom(32'h0));
        end
        tick();
        checks++; if (pc !== 32'h8 || id_pc !== 32'h4 || id_inst !== irom(32'h4)) begin
            errors++; $display("FAIL adv2 got pc=%h id_pc=%h id_inst=%h want pc=8 id_pc=4 id_inst=%h",
                               pc, id_pc, id_inst, irom(32'h4));
        end
    endtask

    // Continues from pc=8 after test_reset: lw at pc 8, dependent add at pc 12.
    task automatic test_load_use();
        tick();
        id_wr = 5'd5; id_isLoad = 1; id_reg_we = 1;
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h8 || ex_wr !== 5'd5 || ex_isLoad !== 1'b1) begin
            errors++; $display("FAIL lw_in_ex got v=%b pc=%h wr=%0d ld=%b want 1/8/5/1",
                               ex_valid, ex_pc, ex_wr, ex_isLoad);
        end
        id_wr = 5'd6; id_isLoad = 0; id_reg_we = 1;
        stop_IF_ID = 1; stop_ID_EX = 1;
        tick();
        checks++; if (pc !== 32'h10 || id_pc !== 32'hC || id_inst !== irom(32'hC)) begin
            errors++; $display("FAIL stall_hold got pc=%h id_pc=%h want pc=10 id_pc=c", pc, id_pc);
        end
        checks++; if (ex_valid !== 1'b0 || ex_wr !== 5'd0 || ex_isLoad !== 1'b0) begin
            errors++; $display("FAIL stall_bubble got v=%b wr=%0d ld=%b want 0/0/0", ex_valid, ex_wr, ex_isLoad);
        end
        checks++; if (stall_cnt !== 2'd1) begin
            errors++; $display("FAIL stall_cnt got %0d want 1", stall_cnt);
        end
        stop_IF_ID = 0; stop_ID_EX = 0;
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'hC || ex_wr !== 5'd6 || pc !== 32'h14) begin
            errors++; $display("FAIL add_in_ex got v=%b ex_pc=%h wr=%0d pc=%h want 1/c/6/14",
                               ex_valid, ex_pc, ex_wr, pc);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 6; i++) tick();
        checks++; if (pc !== 32'h18) begin errors++; $display("FAIL pre_flush_pc got %h want 18", pc); end
        br_taken = 1; br_target = 32'h40;
        tick();
        checks++; if (pc !== 32'h40 || id_valid !== 1'b0 || ex_valid !== 1'b0 || flush_cnt !== 2'd1) begin
            errors++; $display("FAIL flush got pc=%h idv=%b exv=%b fc=%0d want 40/0/0/1",
                               pc, id_valid, ex_valid, flush_cnt);
        end
        br_taken = 0;
        tick();
        checks++; if (id_pc !== 32'h40 || id_valid !== 1'b1 || ex_valid !== 1'b0 || pc !== 32'h44) begin
            errors++; $display("FAIL post_flush got id_pc=%h idv=%b exv=%b pc=%h want 40/1/0/44",
                               id_pc, id_valid, ex_valid, pc);
        end
    endtask

    // Follows test_flush: stall count 0, flush count 1.
    task automatic test_simultaneous();
        br_taken = 1; stop_IF_ID = 1; br_target = 32'h100;
        tick();
        checks++; if (pc !== 32'h100 || stall_cnt !== 2'd0 || flush_cnt !== 2'd2) begin
            errors++; $display("FAIL br_vs_stall got pc=%h sc=%0d fc=%0d want 100/0/2", pc, stall_cnt, flush_cnt);
        end
        clear_inputs();
    endtask

    task automatic test_wrap_saturation();
        br_taken = 1; br_target = 32'hFFFF_FFFC;
        tick();
        br_taken = 0;
        tick();
        checks++; if (pc !== 32'h0 || id_pc !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL pc_wrap got pc=%h id_pc=%h want 0/fffffffc", pc, id_pc);
        end
        checks++; if (flush_cnt !== 2'd3) begin errors++; $display("FAIL flush_cnt3 got %0d want 3", flush_cnt); end
        br_taken = 1; tick(); br_taken = 0;
        checks++; if (flush_cnt !== 2'd3) begin errors++; $display("FAIL flush_sat got %0d want 3", flush_cnt); end
        do_reset();
        stop_IF_ID = 1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++; if (stall_cnt !== 2'((i > 3) ? 3 : i) || pc !== 32'h0) begin
                errors++; $display("FAIL stall_sat[%0d] got sc=%0d pc=%h want %0d/0",
                                   i, stall_cnt, pc, (i > 3) ? 3 : i);
            end
        end
        stop_IF_ID = 0;
    endtask

    task automatic test_reset_mid_stall();
        br_taken = 1; br_target = 32'h200; tick(); br_taken = 0;
        id_wr = 5'd9; id_reg_we = 1; id_bundle = {3{32'hDEAD_BEEF}};
        tick(); tick();
        stop_IF_ID = 1; cpu_rst = 1;
        tick();
        cpu_rst = 0;
        checks++; if (pc !== 32'h0 || id_pc !== 32'h0 || id_inst !== NOP || id_valid !== 1'b0) begin
            errors++; $display("FAIL rst_stall_if got pc=%h id_pc=%h inst=%h v=%b", pc, id_pc, id_inst, id_valid);
        end
        checks++; if ({ex_valid, ex_wr, ex_isLoad, ex_reg_we, ex_pc, ex_bundle} !== '0) begin
            errors++; $display("FAIL rst_stall_ex got v=%b wr=%0d pc=%h want all zero", ex_valid, ex_wr, ex_pc);
        end
        checks++; if (stall_cnt !== 2'd0 || flush_cnt !== 2'd0) begin
            errors++; $display("FAIL rst_stall_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        end
        clear_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cpu_rst    = ($urandom_range(0, 39) == 0);
            br_taken   = ($urandom_range(0, 7) == 0);
            stop_IF_ID = ($urandom_range(0, 5) == 0);
            stop_ID_EX = stop_IF_ID | ($urandom_range(0, 5) == 0);
            br_target  = $urandom;
            id_rs1 = 5'($urandom); id_rs2 = 5'($urandom); id_wr = 5'($urandom);
            id_isLoad = 1'($urandom); id_reg_we = 1'($urandom);
            id_bundle = {$urandom, $urandom, $urandom};
            tick();
            checks++;
            if ({pc, id_pc, id_inst, id_valid, ex_pc, ex_wr, ex_isLoad, ex_reg_we, ex_valid, ex_bundle}
                !== {m_pc, m_id_pc, m_id_inst, m_id_valid, m_ex_pc, m_ex_wr, m_ex_isLoad, m_ex_reg_we,
                     m_ex_valid, m_ex_bundle}) begin
                errors++;
                $display("FAIL rand_pipe[%0d] got pc=%h id=%h/%h/%b ex=%h/%0d/%b/%b/%b want pc=%h id=%h/%h/%b ex=%h/%0d/%b/%b/%b",
                         i, pc, id_pc, id_inst, id_valid, ex_pc, ex_wr, ex_isLoad, ex_reg_we, ex_valid,
                         m_pc, m_id_pc, m_id_inst, m_id_valid, m_ex_pc, m_ex_wr, m_ex_isLoad,
                         m_ex_reg_we, m_ex_valid);
            end
            checks++;
            if (stall_cnt !== 2'(m_stall) || flush_cnt !== 2'(m_flush)) begin
                errors++;
                $display("FAIL rand_cnt[%0d] got %0d/%0d want %0d/%0d", i, stall_cnt, flush_cnt, m_stall, m_flush);
            end
        end
        clear_inputs();
        cpu_rst = 0;
    endtask

    initial begin
        m_pc = '0; m_id_pc = '0; m_id_inst = NOP; m_id_valid = 0;
        m_bubble();
        m_stall = 0; m_flush = 0;
        test_reset();
        test_load_use();
        test_flush();
        test_simultaneous();
        test_wrap_saturation();
        test_reset_mid_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
